sa_autosa_pdp_rdma_ingest: RTL

SA_AUTOSA_PDP_RDMA_INGEST -- requirements
Module: sa_autosa_pdp_rdma_ingest

---
 rtl/sa_autosa_pdp_rdma_ingest_pkg.sv | 40 ++++
 rtl/sa_autosa_pdp_rdma_ingest_if.sv | 13 +
 rtl/sa_autosa_pdp_skid.sv | 61 ++++++
 rtl/sa_autosa_pdp_rdma_ingest.sv | 105 ++++++++++
 4 files changed

// File: rtl/sa_autosa_pdp_rdma_ingest_pkg.sv
// Shared PDP ingest definitions: payload widths, flag bit positions,
// controller states and the small packing helper used by the top.
package sa_autosa_pdp_rdma_ingest_pkg;

  localparam int PD_W         = 78;  // upstream payload: 8 int8 lanes + side info
  localparam int OUT_W        = 81;  // payload plus three position flags
  localparam int NUM_LANES    = 8;
  localparam int LANE_W       = 8;
  localparam int LANE_BITS    = NUM_LANES * LANE_W;
  localparam int LINE_END_BIT = 78;
  localparam int SURF_END_BIT = 79;
  localparam int CUBE_END_BIT = 80;
  localparam int DIM_W        = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ingest_state_e;

  // Ordered MSB-first so {flags, pd} lands cube/surf/line on 80/79/78.
  typedef struct packed {
    logic cube_end;
    logic surf_end;
    logic line_end;
  } pos_flags_t;

  // Latched cube limits; s is the surface count (channels / 8) minus 1.
  typedef struct packed {
    logic [DIM_W-1:0] w;
    logic [DIM_W-1:0] h;
    logic [DIM_W-1:0] s;
  } cube_dims_t;

  function automatic logic [OUT_W-1:0] pack_out(input logic [PD_W-1:0] pd,
                                                input pos_flags_t      f);
    return {f, pd};
  endfunction

endpackage

// File: rtl/sa_autosa_pdp_rdma_ingest_if.sv
// Valid/ready beat channel, width set per instance (78 upstream, 81 downstream).
interface sa_autosa_pdp_rdma_ingest_if
  import sa_autosa_pdp_rdma_ingest_pkg::*;
#(
  parameter int W = PD_W
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] pd;

  modport master (output valid, output pd, input ready);
  modport slave  (input valid, input pd, output ready);
endinterface

// File: rtl/sa_autosa_pdp_skid.sv
// Two-entry skid buffer: head is the registered output, tail absorbs one
// extra beat so upstream ready can be a pure "not full" register decode.
module sa_autosa_pdp_skid
  import sa_autosa_pdp_rdma_ingest_pkg::*;
#(
  parameter int W = OUT_W
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   cnt;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head only moves on pop or on a push into an empty buffer, so the
  // output holds steady for as long as the consumer stalls.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_data;
          else             tail <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) head <= tail;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sa_autosa_pdp_rdma_ingest.sv
// PDP RDMA ingest: tags each beat of a W x H x (C/8) cube with line/surface/
// cube end flags and forwards it through a skid buffer to the calculator.
module sa_autosa_pdp_rdma_ingest
  import sa_autosa_pdp_rdma_ingest_pkg::*;
(
  input  logic                               autosa_core_clk,
  input  logic                               autosa_core_rstn,
  sa_autosa_pdp_rdma_ingest_if.slave         pdp_rdma2dp,
  sa_autosa_pdp_rdma_ingest_if.master        pre2cal,
  input  logic                               reg2dp_op_en,
  input  logic [DIM_W-1:0]                   reg2dp_cube_in_width,
  input  logic [DIM_W-1:0]                   reg2dp_cube_in_height,
  input  logic [DIM_W-1:0]                   reg2dp_cube_in_channel,
  output logic                               ingest_done,
  output logic                               ingest_err
);

  ingest_state_e    state;
  cube_dims_t       lim;
  logic [DIM_W-1:0] w_cnt;
  logic [DIM_W-1:0] h_cnt;
  logic [DIM_W-1:0] s_cnt;
  pos_flags_t       flags;
  logic             skid_in_ready;
  logic             accept;
  logic             drain_done;

  assign pdp_rdma2dp.ready = (state == ST_RUN) & skid_in_ready;
  assign accept            = pdp_rdma2dp.valid & pdp_rdma2dp.ready;
  assign drain_done        = pre2cal.valid & pre2cal.ready & pre2cal.pd[CUBE_END_BIT];

  // Position flags for the beat currently offered upstream.
  always_comb begin
    flags          = '0;
    flags.line_end = (w_cnt == lim.w);
    flags.surf_end = flags.line_end & (h_cnt == lim.h);
    flags.cube_end = flags.surf_end & (s_cnt == lim.s);
  end

  sa_autosa_pdp_skid #(.W(OUT_W)) u_skid (
    .gclk      (autosa_core_clk),
    .grst_n    (autosa_core_rstn),
    .in_valid  (accept),
    .in_ready  (skid_in_ready),
    .in_data   (pack_out(pdp_rdma2dp.pd, flags)),
    .out_valid (pre2cal.valid),
    .out_ready (pre2cal.ready),
    .out_data  (pre2cal.pd)
  );

  // Controller: limit latch, w/h/s position counters, done pulse, sticky error.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state       <= ST_IDLE;
      lim         <= '0;
      w_cnt       <= '0;
      h_cnt       <= '0;
      s_cnt       <= '0;
      ingest_done <= 1'b0;
      ingest_err  <= 1'b0;
    end else begin
      ingest_done <= 1'b0;
      // A beat offered while idle is an overrun; it is left unconsumed.
      if (state == ST_IDLE && pdp_rdma2dp.valid) ingest_err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (reg2dp_op_en) begin
            lim.w <= reg2dp_cube_in_width;
            lim.h <= reg2dp_cube_in_height;
            lim.s <= reg2dp_cube_in_channel >> 3;
            w_cnt <= '0;
            h_cnt <= '0;
            s_cnt <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (flags.line_end) begin
              w_cnt <= '0;
              if (flags.surf_end) begin
                h_cnt <= '0;
                if (flags.cube_end) s_cnt <= '0;
                else                s_cnt <= s_cnt + DIM_W'(1);
              end else begin
                h_cnt <= h_cnt + DIM_W'(1);
              end
            end else begin
              w_cnt <= w_cnt + DIM_W'(1);
            end
            if (flags.cube_end) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state       <= ST_IDLE;
            ingest_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
